tx_engine: RTL and testbench
============================

Name: tx_engine

Overview:
- 64-bit PCIe transaction-layer transmit unit; sits directly downstream of the receive engine and drives the core's AXI-S TX interface.
- Builds 3DW CplD TLPs (1 DW payload) answering register reads captured by the receive engine, and returns compl_done_i to it.
- Also issues 3DW Memory Read request TLPs for the DMA read path, with a rolling tag. The returned completions re-enter through the receive engine (cpld_tag_o).

Parameters:
C_DATA_WIDTH, 64, TX AXI-S data width; only 64 supported.
TAG_BITS, 5, width of the DMA read tag counter; upper tag bits are driven 0.

Ports:
clk_i  in  1  250 MHz core clock
rst_n  in  1  asynchronous active-low reset
s_axis_tx_tdata  out  64  TLP data; DW0 in [31:0], DW1 in [63:32]
s_axis_tx_tkeep  out  8  byte enables
s_axis_tx_tlast  out  1  last beat
s_axis_tx_tvalid  out  1  beat valid
s_axis_tx_tready  in  1  core accepts beat
cfg_completer_id_i  in  16  bus/dev/func for CplD and request requester ID
req_compl_wd_i  in  1  completion request level; held until compl_done_o is seen
compl_done_o  out  1  one-cycle pulse: CplD last beat accepted
tx_reg_data_i  in  32  completion payload
req_tc_i  in  3  echoed TC
req_td_i  in  1  echoed TD
req_ep_i  in  1  echoed EP
req_attr_i  in  2  echoed attributes
req_len_i  in  10  request length (unused; CplD length is fixed 1)
req_rid_i  in  16  requester ID
req_tag_i  in  8  request tag
req_addr_i  in  7  lower address
rd_req_i  in  1  DMA read request pending (level)
rd_addr_i  in  32  DW-aligned byte address
rd_len_i  in  10  length in DW; 0 encodes 1024
rd_ack_o  out  1  one-cycle pulse: read request header accepted
rd_tag_o  out  8  tag used; valid with rd_ack_o
tx_stall_cnt_o  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state IDLE, tag counter 0.
- Beats are registered. Hold tdata, tkeep, tlast and tvalid stable while tvalid && !tready. A beat completes only on tvalid && tready.
- States: IDLE, CPL_H, CPL_D, RD_H, RD_A, WAIT_REQ_LOW.
- IDLE, with req_compl_wd_i=1: go to CPL_H and drive beat 0. Completion has priority over rd_req_i when both are high.
- IDLE, with only rd_req_i=1: capture rd_addr_i, rd_len_i and the current tag; go to RD_H.
- CPL beat 0 = {DW1, DW0}, tkeep FF, tlast 0:
  - DW0: [30:24]=7'b1001010, [22:20]=tc, [15]=td, [14]=ep, [13:12]=attr, [9:0]=1, other bits 0.
  - DW1: [31:16]=completer id, status [15:13]=000, BCM 0, byte count [11:0]=4.
- CPL beat 1 (state CPL_D) = {tx_reg_data_i, DW2}, tkeep FF, tlast 1.
  - DW2: [31:16]=rid, [15:8]=tag, [7]=0, [6:0]=req_addr.
  - On acceptance: pulse compl_done_o, go to WAIT_REQ_LOW.
- WAIT_REQ_LOW: stay until req_compl_wd_i=0, then IDLE. This prevents re-sending while the receive engine drops its level one cycle late.
- RD beat 0 = {DW1, DW0}, tkeep FF:
  - DW0: [30:24]=0, [9:0]=rd_len, all else 0.
  - DW1: [31:16]=completer id, [15:8]=tag, last BE [7:4]=(rd_len==1 ? 0 : F), first BE [3:0]=F.
- RD beat 1 (state RD_A) = {32'h0, addr[31:2], 2'b00}, tkeep 0F, tlast 1.
- rd_ack_o and rd_tag_o: asserted on acceptance of RD beat 0. Tag counter increments on the same edge, wrapping at 2^TAG_BITS-1 → 0. Return to IDLE after beat 1 is accepted.
- Back-to-back: from IDLE, a new TLP starts the cycle after the previous last beat is accepted.
- Asynchronous reset mid-TLP: tvalid drops immediately and the partial TLP is abandoned. The requester side is reset in the same domain.

Optional Feature:
- Macro TX_STALL_CNT_EN.
- Defined: tx_stall_cnt_o counts cycles with tvalid && !tready; saturates at FFFFFFFF; reset to 0.
- Undefined: tx_stall_cnt_o tied to 0 and no counter logic is generated.

Decomposition:
- Shared package pcie_tlp_pkg holds:
  - fmt/type constants MEM_RD 7'b0000000, MEM_WR 7'b1000000, CPLD 7'b1001010;
  - completion status codes;
  - header field bit positions, shared with the receive engine.
- One natural sub-module, tlp_hdr_build: combinational assembly of {DW1, DW0} and DW2 for both TLP kinds; the FSM registers its output.

Test Plan:
- CPL, tready=1: completer 0x0100, rid 0x0008, tag 0x1A, addr 0x14, data 0xDEADBEEF → beat0 = 0x01000004_4A000001, beat1 = 0xDEADBEEF_00081A14 with tlast, single compl_done_o pulse.
- Same CPL with tready low 3 cycles on each beat → data held stable, one TLP, compl_done_o once. With TX_STALL_CNT_EN, counter reads 6.
- req_compl_wd_i held 2 cycles after done → WAIT_REQ_LOW, no second TLP.
- rd_req_i, addr 0x8000_1000, len 32 → DW1 = 0x0100_00FF, beat1 = 0x00000000_80001000, tkeep 0F, rd_ack_o with tag 0; 32 reads → tag wraps 31 → 0.
- rd_req_i and req_compl_wd_i rise together → CplD first, then MRd with no idle beat besides the WAIT_REQ_LOW exit.
- rst_n asserted during CPL beat 1 → tvalid 0 asynchronously, compl_done_o 0, IDLE after release.

Source files
------------

// File: rtl/pcie_tlp_pkg.sv
// PCIe TLP constants and header field layout shared by the RX and TX engines.
// Field positions are DW-relative bit indices.
package pcie_tlp_pkg;

    // Fmt[1:0] and Type[4:0] as the 7-bit field at DW0[30:24]
    localparam logic [6:0] MEM_RD = 7'b0000000;
    localparam logic [6:0] MEM_WR = 7'b1000000;
    localparam logic [6:0] CPLD   = 7'b1001010;

    // Completion status codes
    localparam logic [2:0] CPL_SC  = 3'b000;
    localparam logic [2:0] CPL_UR  = 3'b001;
    localparam logic [2:0] CPL_CRS = 3'b010;
    localparam logic [2:0] CPL_CA  = 3'b100;

    // DW0 fields
    localparam int FT_MSB   = 30;
    localparam int FT_LSB   = 24;
    localparam int TC_MSB   = 22;
    localparam int TC_LSB   = 20;
    localparam int TD_BIT   = 15;
    localparam int EP_BIT   = 14;
    localparam int ATTR_MSB = 13;
    localparam int ATTR_LSB = 12;
    localparam int LEN_MSB  = 9;

    // DW1 fields (completer ID / requester ID share the top half)
    localparam int ID_MSB   = 31;
    localparam int ID_LSB   = 16;
    localparam int STAT_MSB = 15;
    localparam int STAT_LSB = 13;
    localparam int BCM_BIT  = 12;
    localparam int BC_MSB   = 11;
    localparam int TAG_MSB  = 15;
    localparam int TAG_LSB  = 8;
    localparam int LBE_MSB  = 7;
    localparam int LBE_LSB  = 4;
    localparam int FBE_MSB  = 3;

    // DW2 of a completion: requester ID, tag, lower address
    localparam int LA_MSB   = 6;

    typedef enum logic {
        TLP_CPLD = 1'b0,
        TLP_MRD  = 1'b1
    } tlp_kind_e;

    typedef struct packed {
        logic [2:0]  tc;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [6:0]  addr;
    } cpl_req_t;

    // A single-DW request must not enable any last-DW bytes
    function automatic logic [3:0] last_be(input logic [9:0] len);
        return (len == 10'd1) ? 4'h0 : 4'hF;
    endfunction

endpackage

// File: rtl/tlp_hdr_build.sv
// Combinational header assembly for 3DW CplD and 3DW MRd TLPs.
// Produces {DW1, DW0} and DW2; the caller registers the result.
module tlp_hdr_build
    import pcie_tlp_pkg::*;
(
    input  tlp_kind_e   kind,
    input  logic [15:0] completer_id,
    input  cpl_req_t    cpl,
    input  logic [9:0]  rd_len,
    input  logic [7:0]  rd_tag,
    input  logic [29:0] rd_addr,
    output logic [63:0] hdr01,
    output logic [31:0] dw2
);

    logic [31:0] dw0;
    logic [31:0] dw1;

    // Fill the header DWs for whichever TLP kind is selected
    always_comb begin
        dw0 = '0;
        dw1 = '0;
        dw2 = '0;
        if (kind == TLP_CPLD) begin
            dw0[FT_MSB:FT_LSB]     = CPLD;
            dw0[TC_MSB:TC_LSB]     = cpl.tc;
            dw0[TD_BIT]            = cpl.td;
            dw0[EP_BIT]            = cpl.ep;
            dw0[ATTR_MSB:ATTR_LSB] = cpl.attr;
            dw0[LEN_MSB:0]         = 10'd1;
            dw1[ID_MSB:ID_LSB]     = completer_id;
            dw1[STAT_MSB:STAT_LSB] = CPL_SC;
            dw1[BCM_BIT]           = 1'b0;
            dw1[BC_MSB:0]          = 12'd4;
            dw2[ID_MSB:ID_LSB]     = cpl.rid;
            dw2[TAG_MSB:TAG_LSB]   = cpl.tag;
            dw2[LA_MSB:0]          = cpl.addr;
        end else begin
            dw0[FT_MSB:FT_LSB]     = MEM_RD;
            dw0[LEN_MSB:0]         = rd_len;
            dw1[ID_MSB:ID_LSB]     = completer_id;
            dw1[TAG_MSB:TAG_LSB]   = rd_tag;
            dw1[LBE_MSB:LBE_LSB]   = last_be(rd_len);
            dw1[FBE_MSB:0]         = 4'hF;
            dw2                    = {rd_addr, 2'b00};
        end
    end

    assign hdr01 = {dw1, dw0};

endmodule

// File: rtl/tx_engine.sv
// PCIe TX engine: CplD for register reads and MRd for DMA reads.
// Define TX_STALL_CNT_EN to build the tvalid-stall cycle counter.
module tx_engine
    import pcie_tlp_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int TAG_BITS     = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    output logic [C_DATA_WIDTH-1:0]   s_axis_tx_tdata,
    output logic [C_DATA_WIDTH/8-1:0] s_axis_tx_tkeep,
    output logic                      s_axis_tx_tlast,
    output logic                      s_axis_tx_tvalid,
    input  logic                      s_axis_tx_tready,
    input  logic [15:0]               cfg_completer_id_i,
    input  logic                      req_compl_wd_i,
    output logic                      compl_done_o,
    input  logic [31:0]               tx_reg_data_i,
    input  logic [2:0]                req_tc_i,
    input  logic                      req_td_i,
    input  logic                      req_ep_i,
    input  logic [1:0]                req_attr_i,
    input  logic [9:0]                req_len_i,
    input  logic [15:0]               req_rid_i,
    input  logic [7:0]                req_tag_i,
    input  logic [6:0]                req_addr_i,
    input  logic                      rd_req_i,
    input  logic [31:0]               rd_addr_i,
    input  logic [9:0]                rd_len_i,
    output logic                      rd_ack_o,
    output logic [7:0]                rd_tag_o,
    output logic [31:0]               tx_stall_cnt_o
);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] CPL_H        = 3'd1;
    localparam logic [2:0] CPL_D        = 3'd2;
    localparam logic [2:0] RD_H         = 3'd3;
    localparam logic [2:0] RD_A         = 3'd4;
    localparam logic [2:0] WAIT_REQ_LOW = 3'd5;

    logic [2:0]          state;
    logic [TAG_BITS-1:0] tag_cnt;
    logic [7:0]          cur_tag;
    logic [7:0]          rd_tag_q;
    logic [29:0]         rd_addr_q;
    logic [29:0]         hdr_addr;
    tlp_kind_e           hdr_kind;
    cpl_req_t            cpl_req;
    logic [63:0]         hdr01;
    logic [31:0]         hdr_dw2;
    logic                beat_acc;
    logic                unused_ok;

    assign beat_acc  = s_axis_tx_tvalid && s_axis_tx_tready;
    assign cur_tag   = 8'(tag_cnt);
    assign unused_ok = ^{req_len_i, rd_addr_i[1:0]};

    assign cpl_req = '{
        tc:   req_tc_i,
        td:   req_td_i,
        ep:   req_ep_i,
        attr: req_attr_i,
        rid:  req_rid_i,
        tag:  req_tag_i,
        addr: req_addr_i
    };

    // In IDLE build from live inputs; later beats use captured address
    always_comb begin
        hdr_kind = TLP_MRD;
        hdr_addr = rd_addr_q;
        if (state == IDLE) begin
            hdr_kind = req_compl_wd_i ? TLP_CPLD : TLP_MRD;
            hdr_addr = rd_addr_i[31:2];
        end else if (state == CPL_H || state == CPL_D) begin
            hdr_kind = TLP_CPLD;
        end
    end

    tlp_hdr_build u_hdr (
        .kind         (hdr_kind),
        .completer_id (cfg_completer_id_i),
        .cpl          (cpl_req),
        .rd_len       (rd_len_i),
        .rd_tag       (cur_tag),
        .rd_addr      (hdr_addr),
        .hdr01        (hdr01),
        .dw2          (hdr_dw2)
    );

    // TLP sequencer with registered AXI-S beats and handshake pulses
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            tag_cnt          <= '0;
            rd_tag_q         <= '0;
            rd_addr_q        <= '0;
            s_axis_tx_tdata  <= '0;
            s_axis_tx_tkeep  <= '0;
            s_axis_tx_tlast  <= 1'b0;
            s_axis_tx_tvalid <= 1'b0;
            compl_done_o     <= 1'b0;
            rd_ack_o         <= 1'b0;
            rd_tag_o         <= '0;
        end else begin
            compl_done_o <= 1'b0;
            rd_ack_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_compl_wd_i) begin
                        s_axis_tx_tdata  <= hdr01;
                        s_axis_tx_tkeep  <= 8'hFF;
                        s_axis_tx_tlast  <= 1'b0;
                        s_axis_tx_tvalid <= 1'b1;
                        state            <= CPL_H;
                    end else if (rd_req_i) begin
                        s_axis_tx_tdata  <= hdr01;
                        s_axis_tx_tkeep  <= 8'hFF;
                        s_axis_tx_tlast  <= 1'b0;
                        s_axis_tx_tvalid <= 1'b1;
                        rd_addr_q        <= rd_addr_i[31:2];
                        rd_tag_q         <= cur_tag;
                        state            <= RD_H;
                    end
                end
                CPL_H: begin
                    if (beat_acc) begin
                        s_axis_tx_tdata <= {tx_reg_data_i, hdr_dw2};
                        s_axis_tx_tlast <= 1'b1;
                        state           <= CPL_D;
                    end
                end
                CPL_D: begin
                    if (beat_acc) begin
                        s_axis_tx_tdata  <= '0;
                        s_axis_tx_tkeep  <= '0;
                        s_axis_tx_tlast  <= 1'b0;
                        s_axis_tx_tvalid <= 1'b0;
                        compl_done_o     <= 1'b1;
                        state            <= WAIT_REQ_LOW;
                    end
                end
                RD_H: begin
                    if (beat_acc) begin
                        s_axis_tx_tdata <= {32'h0, hdr_dw2};
                        s_axis_tx_tkeep <= 8'h0F;
                        s_axis_tx_tlast <= 1'b1;
                        rd_ack_o        <= 1'b1;
                        rd_tag_o        <= rd_tag_q;
                        tag_cnt         <= tag_cnt + 1'b1;
                        state           <= RD_A;
                    end
                end
                RD_A: begin
                    if (beat_acc) begin
                        s_axis_tx_tdata  <= '0;
                        s_axis_tx_tkeep  <= '0;
                        s_axis_tx_tlast  <= 1'b0;
                        s_axis_tx_tvalid <= 1'b0;
                        state            <= IDLE;
                    end
                end
                WAIT_REQ_LOW: begin
                    if (!req_compl_wd_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    s_axis_tx_tvalid <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

`ifdef TX_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Count back-pressure cycles, sticking at all-ones
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (s_axis_tx_tvalid && !s_axis_tx_tready
                     && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign tx_stall_cnt_o = stall_cnt;
`else
    assign tx_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tx_engine.sv
// Bench for tx_engine: expected-beat scoreboard, pulse and hold checks.
// Directed CplD/MRd vectors with literal pins on key beats.
module tb_tx_engine;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic        s_axis_tx_tlast;
    logic        s_axis_tx_tvalid;
    logic        s_axis_tx_tready;
    logic [15:0] cfg_completer_id_i;
    logic        req_compl_wd_i;
    logic        compl_done_o;
    logic [31:0] tx_reg_data_i;
    logic [2:0]  req_tc_i;
    logic        req_td_i;
    logic        req_ep_i;
    logic [1:0]  req_attr_i;
    logic [9:0]  req_len_i;
    logic [15:0] req_rid_i;
    logic [7:0]  req_tag_i;
    logic [6:0]  req_addr_i;
    logic        rd_req_i;
    logic [31:0] rd_addr_i;
    logic [9:0]  rd_len_i;
    logic        rd_ack_o;
    logic [7:0]  rd_tag_o;
    logic [31:0] tx_stall_cnt_o;

    always #5 clk_i = ~clk_i;

    tx_engine #(.C_DATA_WIDTH(64), .TAG_BITS(5)) dut (
        .clk_i              (clk_i),
        .rst_n              (rst_n),
        .s_axis_tx_tdata    (s_axis_tx_tdata),
        .s_axis_tx_tkeep    (s_axis_tx_tkeep),
        .s_axis_tx_tlast    (s_axis_tx_tlast),
        .s_axis_tx_tvalid   (s_axis_tx_tvalid),
        .s_axis_tx_tready   (s_axis_tx_tready),
        .cfg_completer_id_i (cfg_completer_id_i),
        .req_compl_wd_i     (req_compl_wd_i),
        .compl_done_o       (compl_done_o),
        .tx_reg_data_i      (tx_reg_data_i),
        .req_tc_i           (req_tc_i),
        .req_td_i           (req_td_i),
        .req_ep_i           (req_ep_i),
        .req_attr_i         (req_attr_i),
        .req_len_i          (req_len_i),
        .req_rid_i          (req_rid_i),
        .req_tag_i          (req_tag_i),
        .req_addr_i         (req_addr_i),
        .rd_req_i           (rd_req_i),
        .rd_addr_i          (rd_addr_i),
        .rd_len_i           (rd_len_i),
        .rd_ack_o           (rd_ack_o),
        .rd_tag_o           (rd_tag_o),
        .tx_stall_cnt_o     (tx_stall_cnt_o)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        bit          is_cpl;
        logic [7:0]  tag;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] log_q[$];
    logic [7:0]  ack_tags[$];
    int          checks = 0;
    int          errors = 0;
    int          model_tag = 0;
    int          stall_seen = 0;
    bit          stall_mode = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] cpl_b0(
        input logic [15:0] cid, input logic [2:0] tc, input logic td,
        input logic ep, input logic [1:0] attr);
        logic [31:0] dw0;
        logic [31:0] dw1;
        dw0 = 32'h4A00_0000 | (32'(tc) << 20) | (32'(td) << 15)
            | (32'(ep) << 14) | (32'(attr) << 12) | 32'd1;
        dw1 = (32'(cid) << 16) | 32'd4;
        return {dw1, dw0};
    endfunction

    function automatic logic [63:0] cpl_b1(
        input logic [31:0] data, input logic [15:0] rid,
        input logic [7:0] tag, input logic [6:0] addr);
        logic [31:0] dw2;
        dw2 = (32'(rid) << 16) + (32'(tag) << 8) + 32'(addr);
        return {data, dw2};
    endfunction

    function automatic logic [63:0] rd_b0(
        input logic [15:0] cid, input logic [7:0] tag,
        input logic [9:0] len);
        logic [31:0] dw0;
        logic [31:0] dw1;
        dw0 = 32'(len);
        dw1 = (32'(cid) << 16) + (32'(tag) << 8)
            + ((len == 10'd1) ? 32'h0 : 32'hF0) + 32'hF;
        return {dw1, dw0};
    endfunction

    // Drive completion request fields and queue the expected CplD
    task automatic set_cpl(
        input logic [15:0] cid, input logic [2:0] tc, input logic td,
        input logic ep, input logic [1:0] attr, input logic [15:0] rid,
        input logic [7:0] tag, input logic [6:0] addr,
        input logic [31:0] data);
        cfg_completer_id_i = cid;
        req_tc_i = tc;
        req_td_i = td;
        req_ep_i = ep;
        req_attr_i = attr;
        req_rid_i = rid;
        req_tag_i = tag;
        req_addr_i = addr;
        tx_reg_data_i = data;
        exp_q.push_back('{cpl_b0(cid, tc, td, ep, attr), 8'hFF, 1'b0,
                          1'b1, 8'h0});
        exp_q.push_back('{cpl_b1(data, rid, tag, addr), 8'hFF, 1'b1,
                          1'b1, 8'h0});
    endtask

    // Drive a DMA read and queue the expected MRd with the next tag
    task automatic set_rd(input logic [31:0] addr, input logic [9:0] len);
        logic [7:0] t;
        t = 8'(model_tag);
        rd_addr_i = addr;
        rd_len_i = len;
        exp_q.push_back('{rd_b0(cfg_completer_id_i, t, len), 8'hFF, 1'b0,
                          1'b0, t});
        exp_q.push_back('{{32'h0, addr & 32'hFFFF_FFFC}, 8'h0F, 1'b1,
                          1'b0, t});
        model_tag = (model_tag + 1) % 32;
    endtask

    // Requester behaviour: drop levels when the engine acknowledges
    task automatic run(input int hold_extra, input string name);
        int hold;
        int cyc;
        hold = -1;
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (compl_done_o && req_compl_wd_i) hold = hold_extra;
            else if (hold > 0) hold--;
            if (hold == 0) begin
                req_compl_wd_i = 1'b0;
                hold = -1;
            end
            if (rd_ack_o) rd_req_i = 1'b0;
            if (!req_compl_wd_i && !rd_req_i && exp_q.size() == 0
                && !s_axis_tx_tvalid) break;
        end
        if (cyc >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d cycles required <400",
                     name, cyc);
        end
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    // Back-pressure: three stalled cycles per beat when enabled
    int hold_cnt = 0;
    bit tv_prev = 0;
    always @(posedge clk_i) begin
        #1;
        if (!tv_prev || s_axis_tx_tready) hold_cnt = 0;
        else hold_cnt++;
        s_axis_tx_tready = stall_mode ? (s_axis_tx_tvalid && hold_cnt >= 3)
                                      : 1'b1;
        tv_prev = s_axis_tx_tvalid;
    end

    // Compare process: beats, pulses and stall stability every cycle
    bit          done_due = 0;
    bit          ack_due = 0;
    logic [7:0]  ack_tag = 0;
    bit          prev_stall = 0;
    logic [63:0] pd = 0;
    logic [8:0]  pkl = 0;
    always @(negedge clk_i) begin
        beat_t b;
        if (!rst_n) begin
            exp_q.delete();
            done_due = 0;
            ack_due = 0;
            prev_stall = 0;
            chk("rst_tvalid", s_axis_tx_tvalid, 0);
            chk("rst_done", compl_done_o, 0);
            chk("rst_ack", rd_ack_o, 0);
        end else begin
            chk("compl_done", compl_done_o, done_due);
            chk("rd_ack", rd_ack_o, ack_due);
            if (ack_due) chk("rd_tag", rd_tag_o, ack_tag);
            if (rd_ack_o) ack_tags.push_back(rd_tag_o);
            done_due = 0;
            ack_due = 0;
            if (prev_stall) begin
                chk("hold_valid", s_axis_tx_tvalid, 1);
                chk("hold_data", s_axis_tx_tdata, pd);
                chk("hold_keep_last", {s_axis_tx_tkeep, s_axis_tx_tlast},
                    pkl);
            end
            if (s_axis_tx_tvalid && s_axis_tx_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected none",
                             s_axis_tx_tdata);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", s_axis_tx_tdata, b.data);
                    chk("beat_keep_last",
                        {s_axis_tx_tkeep, s_axis_tx_tlast},
                        {b.keep, b.last});
                    log_q.push_back(s_axis_tx_tdata);
                    if (b.last && b.is_cpl) done_due = 1;
                    if (!b.last && !b.is_cpl) begin
                        ack_due = 1;
                        ack_tag = b.tag;
                    end
                end
            end
            prev_stall = s_axis_tx_tvalid && !s_axis_tx_tready;
            if (prev_stall) stall_seen++;
            pd = s_axis_tx_tdata;
            pkl = {s_axis_tx_tkeep, s_axis_tx_tlast};
        end
    end

    initial begin
        int base;
        int s0;
        int found;
        logic [31:0] c0;
        rst_n = 1'b0;
        s_axis_tx_tready = 1'b1;
        cfg_completer_id_i = 16'h0100;
        req_compl_wd_i = 0;
        tx_reg_data_i = 0;
        req_tc_i = 0;
        req_td_i = 0;
        req_ep_i = 0;
        req_attr_i = 0;
        req_len_i = 10'd1;
        req_rid_i = 0;
        req_tag_i = 0;
        req_addr_i = 0;
        rd_req_i = 0;
        rd_addr_i = 0;
        rd_len_i = 0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        chk("rst_stall_cnt", tx_stall_cnt_o, 0);
        chk("rst_tag", rd_tag_o, 0);

        // Basic CplD
        base = log_q.size();
        set_cpl(16'h0100, 0, 0, 0, 0, 16'h0008, 8'h1A, 7'h14, 32'hDEADBEEF);
        req_compl_wd_i = 1;
        run(0, "cpl");
        chk("lit_cpl_b0", log_q[base], 64'h01000004_4A000001);
        chk("lit_cpl_b1", log_q[base + 1], 64'hDEADBEEF_00081A14);

        // Same CplD under back-pressure
        stall_mode = 1;
        s0 = stall_seen;
        c0 = tx_stall_cnt_o;
        set_cpl(16'h0100, 0, 0, 0, 0, 16'h0008, 8'h1A, 7'h14, 32'hDEADBEEF);
        req_compl_wd_i = 1;
        run(0, "cpl_stall");
        stall_mode = 0;
        chk("stall_cycles", 64'(stall_seen - s0), 6);
`ifdef TX_STALL_CNT_EN
        chk("stall_cnt", tx_stall_cnt_o - c0, 6);
`else
        chk("stall_cnt_off", tx_stall_cnt_o, 0);
`endif

        // Request level held two cycles past done; other field values
        base = log_q.size();
        set_cpl(16'h0A0B, 3'd3, 1, 0, 2'd1, 16'hBEEF, 8'hC3, 7'h7F,
                32'h1234_5678);
        req_compl_wd_i = 1;
        run(2, "cpl_hold");
        chk("lit_cpl2_b0", log_q[base], 64'h0A0B0004_4A309001);
        chk("lit_cpl2_b1", log_q[base + 1], 64'h12345678_BEEFC37F);
        cfg_completer_id_i = 16'h0100;

        // MRd, len 32
        base = log_q.size();
        set_rd(32'h8000_1000, 10'd32);
        rd_req_i = 1;
        run(0, "rd32");
        chk("lit_rd_b0", log_q[base], 64'h010000FF_00000020);
        chk("lit_rd_b1", log_q[base + 1], 64'h00000000_80001000);
        chk("lit_rd_tag0", ack_tags[ack_tags.size() - 1], 0);

        // MRd len 1 (no last BE) and len 0 (1024 DW)
        base = log_q.size();
        set_rd(32'h0000_0FFC, 10'd1);
        rd_req_i = 1;
        run(0, "rd1");
        chk("lit_rd1_b0", log_q[base], 64'h0100010F_00000001);
        chk("lit_rd1_b1", log_q[base + 1], 64'h00000000_00000FFC);
        base = log_q.size();
        set_rd(32'hFFFF_FFFC, 10'd0);
        rd_req_i = 1;
        run(0, "rd1024");
        chk("lit_rd0_b0", log_q[base], 64'h010002FF_00000000);

        // Tag wrap: tags 3..31 then 0
        for (int i = 0; i < 30; i++) begin
            set_rd(32'h1000_0000 + 32'(i * 64), 10'(i + 1));
            rd_req_i = 1;
            run(0, "rd_wrap");
        end
        chk("lit_tag31", ack_tags[ack_tags.size() - 2], 8'h1F);
        chk("lit_tag_wrap", ack_tags[ack_tags.size() - 1], 8'h00);

        // Completion and read requested together: CplD goes first
        base = log_q.size();
        set_cpl(16'h0100, 3'd7, 0, 1, 2'd3, 16'h0001, 8'h02, 7'h03,
                32'hCAFE_F00D);
        set_rd(32'h0000_0040, 10'd4);
        req_compl_wd_i = 1;
        rd_req_i = 1;
        run(0, "both");
        chk("lit_both_first", log_q[base + 1], 64'hCAFEF00D_00010203);
        chk("lit_both_rd", log_q[base + 2], 64'h010001FF_00000004);

        // Asynchronous reset while CplD beat 1 is on the bus
        set_cpl(16'h0100, 0, 0, 0, 0, 16'h0008, 8'h1A, 7'h14, 32'hDEADBEEF);
        @(posedge clk_i);
        #1;
        req_compl_wd_i = 1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i);
            #1;
            if (s_axis_tx_tvalid && s_axis_tx_tlast) begin
                found = 1;
                break;
            end
        end
        chk("reach_beat1", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_tvalid", s_axis_tx_tvalid, 0);
        chk("async_done", compl_done_o, 0);
        req_compl_wd_i = 0;
        rd_req_i = 0;
        model_tag = 0;
        repeat (2) @(posedge clk_i);
        #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("post_rst_idle", s_axis_tx_tvalid, 0);

        // Fresh read after reset restarts at tag 0
        set_rd(32'h0000_2000, 10'd2);
        rd_req_i = 1;
        run(0, "rd_after_rst");
        chk("lit_tag_after_rst", ack_tags[ack_tags.size() - 1], 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
